// File: rtl/jtag_tap_sync_if.sv
// Pad-side JTAG signals of the TAP: the tester/pad drives TCK/TMS/TDI/TRSTn,
// and the TAP returns TDO with its output enable.
interface jtag_tap_sync_if;
    logic jtag_tck_i;
    logic jtag_tms_i;
    logic jtag_tdi_i;
    logic jtag_trst_ni;
    logic jtag_tdo_o;
    logic jtag_tdo_oe_o;

    modport master (
        output jtag_tck_i, jtag_tms_i, jtag_tdi_i, jtag_trst_ni,
        input  jtag_tdo_o, jtag_tdo_oe_o
    );

    modport slave (
        input  jtag_tck_i, jtag_tms_i, jtag_tdi_i, jtag_trst_ni,
        output jtag_tdo_o, jtag_tdo_oe_o
    );
endinterface

// File: rtl/jtag_tap_sync.sv
// Oversampling IEEE 1149.1 TAP controller running entirely in the clk_i domain.
// Pad pins are synchronized, TCK edges detected, and chain strobes are state levels.
module jtag_tap_sync #(
    parameter int unsigned         IR_WIDTH    = 5,
    parameter int unsigned         NUM_DR      = 2,
    parameter logic [IR_WIDTH-1:0] USER_BASE   = 5'h08,
    parameter logic [31:0]         IDCODE_VAL  = 32'h1000_2A5B,
    parameter int unsigned         SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    jtag_tap_sync_if.slave      jtag,
    output logic                enable_o,
    output logic                tdi_o,
    output logic [NUM_DR-1:0]   capture_dr_o,
    output logic [NUM_DR-1:0]   shift_dr_o,
    output logic [NUM_DR-1:0]   update_dr_o,
    input  logic [NUM_DR-1:0]   scan_out_i,
    output logic [IR_WIDTH-1:0] ir_o
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_e;

    localparam int SM = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q, trst_sync_q;
    logic                   tck_prev_q, rise_q, fall_q, tms_q, tdi_q;
    logic                   tck_rise, tck_fall, trst_n_s, step;

    // Registering the edge pulse together with tms/tdi keeps enable_o, tdi_o and
    // the state-level strobes aligned: the FSM leaves a state at the end of the
    // enable_o cycle, so a chain sees its strobe for the state being exited.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '1;
            tdi_sync_q  <= '0;
            trst_sync_q <= '1;
            tck_prev_q  <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
        end else begin
            tck_sync_q  <= {tck_sync_q[SYNC_STAGES-2:0], jtag.jtag_tck_i};
            tms_sync_q  <= {tms_sync_q[SYNC_STAGES-2:0], jtag.jtag_tms_i};
            tdi_sync_q  <= {tdi_sync_q[SYNC_STAGES-2:0], jtag.jtag_tdi_i};
            trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], jtag.jtag_trst_ni};
            tck_prev_q  <= tck_sync_q[SM];
            rise_q      <= tck_rise;
            fall_q      <= tck_fall;
            tms_q       <= tms_sync_q[SM];
            tdi_q       <= tdi_sync_q[SM];
        end
    end

    assign tck_rise = tck_sync_q[SM] & ~tck_prev_q;
    assign tck_fall = ~tck_sync_q[SM] & tck_prev_q;
    assign trst_n_s = trst_sync_q[SM];
    assign step     = rise_q & trst_n_s;
    assign enable_o = rise_q;
    assign tdi_o    = tdi_q;

    tap_state_e state_q, state_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= TLR;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!trst_n_s) begin
            state_d = TLR;
        end else if (rise_q) begin
            case (state_q)
                TLR:     state_d = tms_q ? TLR    : RTI;
                RTI:     state_d = tms_q ? SEL_DR : RTI;
                SEL_DR:  state_d = tms_q ? SEL_IR : CAP_DR;
                CAP_DR:  state_d = tms_q ? EX1_DR : SH_DR;
                SH_DR:   state_d = tms_q ? EX1_DR : SH_DR;
                EX1_DR:  state_d = tms_q ? UPD_DR : PA_DR;
                PA_DR:   state_d = tms_q ? EX2_DR : PA_DR;
                EX2_DR:  state_d = tms_q ? UPD_DR : SH_DR;
                UPD_DR:  state_d = tms_q ? SEL_DR : RTI;
                SEL_IR:  state_d = tms_q ? TLR    : CAP_IR;
                CAP_IR:  state_d = tms_q ? EX1_IR : SH_IR;
                SH_IR:   state_d = tms_q ? EX1_IR : SH_IR;
                EX1_IR:  state_d = tms_q ? UPD_IR : PA_IR;
                PA_IR:   state_d = tms_q ? EX2_IR : PA_IR;
                EX2_IR:  state_d = tms_q ? UPD_IR : SH_IR;
                UPD_IR:  state_d = tms_q ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    logic [IR_WIDTH-1:0] ir_shift_q, ir_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ir_shift_q <= '0;
            ir_q       <= IR_WIDTH'(1);
        end else if (!trst_n_s) begin
            ir_q <= IR_WIDTH'(1);
        end else begin
            if (state_q == TLR) ir_q <= IR_WIDTH'(1);
            if (step) begin
                case (state_q)
                    CAP_IR:  ir_shift_q <= IR_WIDTH'(1);
                    SH_IR:   ir_shift_q <= {tdi_q, ir_shift_q[IR_WIDTH-1:1]};
                    UPD_IR:  ir_q       <= ir_shift_q;
                    default: ;
                endcase
            end
        end
    end

    assign ir_o = (state_q == TLR) ? IR_WIDTH'(1) : ir_q;

    logic              sel_idcode;
    logic [NUM_DR-1:0] user_sel;

    assign sel_idcode = (ir_o == IR_WIDTH'(1));

    always_comb begin
        user_sel = '0;
        for (int k = 0; k < NUM_DR; k++) begin
            user_sel[k] = (ir_o == USER_BASE + IR_WIDTH'(k));
        end
    end

    assign capture_dr_o = (state_q == CAP_DR) ? user_sel : '0;
    assign shift_dr_o   = (state_q == SH_DR)  ? user_sel : '0;
    assign update_dr_o  = (state_q == UPD_DR) ? user_sel : '0;

    logic [31:0] idcode_q;
    logic        bypass_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idcode_q <= '0;
            bypass_q <= 1'b0;
        end else if (step) begin
            if (state_q == CAP_DR) begin
                bypass_q <= 1'b0;
                if (sel_idcode) idcode_q <= IDCODE_VAL;
            end else if (state_q == SH_DR) begin
                bypass_q <= tdi_q;
                if (sel_idcode) idcode_q <= {tdi_q, idcode_q[31:1]};
            end
        end
    end

    logic dr_tdo, tdo_q, tdo_oe_q;

    always_comb begin
        dr_tdo = bypass_q;
        if (sel_idcode) dr_tdo = idcode_q[0];
        for (int k = 0; k < NUM_DR; k++) begin
            if (user_sel[k]) dr_tdo = scan_out_i[k];
        end
    end

    // TDO changes only on the falling TCK so the pad sees it stable at the next rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else if (fall_q) begin
            case (state_q)
                SH_IR: begin
                    tdo_q    <= ir_shift_q[0];
                    tdo_oe_q <= 1'b1;
                end
                SH_DR: begin
                    tdo_q    <= dr_tdo;
                    tdo_oe_q <= 1'b1;
                end
                default: tdo_oe_q <= 1'b0;
            endcase
        end
    end

    assign jtag.jtag_tdo_o    = tdo_q;
    assign jtag.jtag_tdo_oe_o = tdo_oe_q;

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Directed bench for jtag_tap_sync: pad-level TCK cycles, scoreboard of expected
// TDO bits, and strobe/enable counters sampled on the falling clk edge.
module tb_jtag_tap_sync;
    localparam int unsigned IR_WIDTH = 5;
    localparam int unsigned NUM_DR   = 2;
    localparam logic [31:0] IDCODE   = 32'h1000_2A5B;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtag_tap_sync_if jif();

    logic                enable, tdi_o;
    logic [NUM_DR-1:0]   cap, sh, upd;
    logic [NUM_DR-1:0]   scan_out = '0;
    logic [IR_WIDTH-1:0] ir;

    jtag_tap_sync #(
        .IR_WIDTH(IR_WIDTH), .NUM_DR(NUM_DR), .USER_BASE(5'h08),
        .IDCODE_VAL(IDCODE), .SYNC_STAGES(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .jtag(jif),
        .enable_o(enable), .tdi_o(tdi_o),
        .capture_dr_o(cap), .shift_dr_o(sh), .update_dr_o(upd),
        .scan_out_i(scan_out), .ir_o(ir)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    // Monitor counters, written only here.
    int en_cnt = 0, upd_any_cnt = 0, strobe0_cnt = 0;
    int cap_en[NUM_DR], sh_en[NUM_DR], upd_en[NUM_DR];
    initial for (int k = 0; k < NUM_DR; k++) begin cap_en[k] = 0; sh_en[k] = 0; upd_en[k] = 0; end

    always @(negedge clk) begin
        if (enable === 1'b1) en_cnt++;
        if (upd !== '0) upd_any_cnt++;
        if ((cap[0] | sh[0] | upd[0]) === 1'b1) strobe0_cnt++;
        for (int k = 0; k < NUM_DR; k++) begin
            if ((enable & cap[k]) === 1'b1) cap_en[k]++;
            if ((enable & sh[k]) === 1'b1)  sh_en[k]++;
            if ((enable & upd[k]) === 1'b1) upd_en[k]++;
        end
    end

    logic last_tdo, last_oe;
    int   last_en, last_lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed %0h expected <entry>", obs);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    // One full TCK period at the pad: setup, 5 clk high, 5 clk low, then sample TDO.
    task automatic tck_cycle(input logic tms_v, input logic tdi_v);
        int seen, lat;
        seen = 0;
        lat  = 0;
        jif.jtag_tms_i = tms_v;
        jif.jtag_tdi_i = tdi_v;
        repeat (4) begin @(negedge clk); if (enable === 1'b1) seen++; end
        jif.jtag_tck_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (enable === 1'b1) begin
                seen++;
                if (lat == 0) lat = i;
            end
        end
        jif.jtag_tck_i = 1'b0;
        repeat (5) begin @(negedge clk); if (enable === 1'b1) seen++; end
        last_en  = seen;
        last_lat = lat;
        last_tdo = jif.jtag_tdo_o;
        last_oe  = jif.jtag_tdo_oe_o;
    endtask

    task automatic goto_tlr();
        repeat (5) tck_cycle(1'b1, 1'b0);
    endtask

    task automatic ir_load(input logic [IR_WIDTH-1:0] v);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < IR_WIDTH - 1; i++) tck_cycle(1'b0, v[i]);
        tck_cycle(1'b1, v[IR_WIDTH-1]);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0]         idv;
        logic [3:0]          pat;
        logic [7:0]          sp;
        logic [IR_WIDTH-1:0] cap_obs;
        int c0, s0, u0, c1, s1, u1, z0, up0, e0, lat;

        idv = IDCODE;
        jif.jtag_tck_i   = 1'b0;
        jif.jtag_tms_i   = 1'b1;
        jif.jtag_tdi_i   = 1'b0;
        jif.jtag_trst_ni = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ir", ir, 1);
        check("rst_oe", jif.jtag_tdo_oe_o, 0);
        check("rst_tdo", jif.jtag_tdo_o, 0);
        check("rst_enable", enable, 0);
        check("rst_strobes", {cap, sh, upd}, 0);
        check("rst_tdi_o", tdi_o, 0);
        rst = 1'b0;

        // TLR with TMS=1: one enable per TCK, 3 clk after the pad rise
        for (int n = 0; n < 5; n++) begin
            tck_cycle(1'b1, 1'b0);
            check("tlr_enable_latency", last_lat, 3);
            check("tlr_enable_count", last_en, 1);
            check("tlr_ir", ir, 1);
            check("tlr_oe", last_oe, 0);
        end
        check("tlr_strobes", {cap, sh, upd}, 0);

        // IDCODE readout
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            push("idcode_bit", idv[i]);
            tck_cycle(1'b0, 1'b0);
            pop_check(last_tdo);
            check("idcode_oe", last_oe, 1);
        end
        tck_cycle(1'b1, 1'b0);
        check("idcode_oe_exit", last_oe, 0);
        goto_tlr();

        // IR scan of all-ones, capturing the shifted-out value
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        push("ir_captured", 5'b00001);
        cap_obs = '0;
        for (int i = 0; i < IR_WIDTH; i++) begin
            tck_cycle(1'b0, 1'b1);
            cap_obs[i] = last_tdo;
        end
        pop_check(cap_obs);
        tck_cycle(1'b1, 1'b1);
        check("ir_oe_exit", last_oe, 0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        check("ir_bypass_loaded", ir, 5'h1F);

        // BYPASS DR scan: pattern 1,0,1,1 comes out delayed by one bit
        pat = 4'b1101;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        push("bypass_out", 0);
        tck_cycle(1'b0, 1'b0);
        pop_check(last_tdo);
        for (int j = 0; j < 3; j++) begin
            push("bypass_out", pat[j]);
            tck_cycle(1'b0, pat[j]);
            pop_check(last_tdo);
        end
        tck_cycle(1'b1, pat[3]);
        check("bypass_oe_exit", last_oe, 0);
        goto_tlr();

        // User DR 1
        ir_load(5'h09);
        check("user_ir", ir, 5'h09);
        c0 = cap_en[1]; s0 = sh_en[1]; u0 = upd_en[1];
        c1 = cap_en[0]; s1 = sh_en[0]; u1 = upd_en[0];
        z0 = strobe0_cnt;
        sp = 8'b1011_0010;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            scan_out = {sp[j], ~sp[j]};
            push("user_tdo", sp[j]);
            tck_cycle(1'b0, j[0]);
            pop_check(last_tdo);
        end
        check("user_shift_oe", last_oe, 1);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        check("user_capture_enables", cap_en[1] - c0, 1);
        check("user_shift_enables", sh_en[1] - s0, 8);
        check("user_update_enables", upd_en[1] - u0, 1);
        check("user_bit0_enables", (cap_en[0] - c1) + (sh_en[0] - s1) + (upd_en[0] - u1), 0);
        check("user_bit0_levels", strobe0_cnt - z0, 0);
        goto_tlr();

        // TRST in SH_DR with IR=USER_BASE
        ir_load(5'h08);
        check("trst_ir", ir, 5'h08);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b1);
        tck_cycle(1'b0, 1'b0);
        check("trst_pre_shift", sh, 2'b01);
        up0 = upd_any_cnt;
        jif.jtag_trst_ni = 1'b0;
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (lat == 0 && ir === 5'h01 && {cap, sh, upd} === '0) lat = i;
        end
        jif.jtag_trst_ni = 1'b1;
        check("trst_response_in_3clk", (lat >= 1 && lat <= 3), 1);
        check("trst_ir", ir, 1);
        check("trst_strobes", {cap, sh, upd}, 0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        push("trst_idcode_bit0", idv[0]);
        tck_cycle(1'b0, 1'b0);
        pop_check(last_tdo);
        check("trst_idcode_oe", last_oe, 1);
        goto_tlr();
        check("trst_no_update", upd_any_cnt - up0, 0);

        // Synchronous reset in SH_IR
        ir_load(5'h1F);
        check("srst_ir_pre", ir, 5'h1F);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b1);
        check("srst_pre_oe", last_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("srst_ir", ir, 1);
        check("srst_oe", jif.jtag_tdo_oe_o, 0);
        check("srst_strobes", {cap, sh, upd}, 0);
        e0 = en_cnt;
        repeat (6) @(negedge clk);
        check("srst_no_false_enable", en_cnt - e0, 0);
        tck_cycle(1'b1, 1'b0);
        check("srst_enable_count", last_en, 1);
        check("srst_enable_latency", last_lat, 3);
        check("srst_ir_after", ir, 1);
        check("srst_oe_after", last_oe, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtag_tap_sync.md
Name: jtag_tap_sync

Overview:
- Oversampling IEEE 1149.1 TAP controller running entirely in the system clock domain.
- Synchronizes the pad TCK/TMS/TDI/TRSTn and detects TCK edges.
- Runs the 16-state TAP FSM and holds the instruction register, IDCODE and BYPASS registers.
- Drives the per-chain enable/capture/shift/update strobes that the user scan chains (bscell chains) consume, and muxes their scan outputs onto TDO.

Parameters:
- IR_WIDTH, 5: instruction register width.
- NUM_DR, 2: number of external user data registers (scan chains).
- USER_BASE, 5'h08: instruction USER_BASE+k selects user DR k, for k < NUM_DR.
- IDCODE_VAL, 32'h1000_2A5B: IDCODE value; bit0 must be 1.
- SYNC_STAGES, 2: synchronizer flops per pad input, minimum 2.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- jtag_tck_i  in  1  pad TCK (asynchronous)
- jtag_tms_i  in  1  pad TMS (asynchronous)
- jtag_tdi_i  in  1  pad TDI (asynchronous)
- jtag_trst_ni  in  1  pad TRSTn (asynchronous, active-low)
- jtag_tdo_o  out  1  TDO
- jtag_tdo_oe_o  out  1  TDO output enable
- enable_o  out  1  one-clk_i pulse per synchronized TCK rising edge
- tdi_o  out  1  synchronized TDI, feeds chain scan_in (chains instantiated with SYNC=0)
- capture_dr_o  out  NUM_DR  bit k = state CAPTURE_DR and DR k selected
- shift_dr_o  out  NUM_DR  bit k = state SHIFT_DR and DR k selected
- update_dr_o  out  NUM_DR  bit k = state UPDATE_DR and DR k selected
- scan_out_i  in  NUM_DR  scan outputs of the user chains
- ir_o  out  IR_WIDTH  current instruction

Behaviour:
- Synchronization:
  - tck, tms, tdi and trst_n each pass through SYNC_STAGES flops, plus one extra tck flop for edge detect.
  - tck_rise = sync_tck & ~prev_tck; tck_fall = ~sync_tck & prev_tck.
  - tms and tdi use the same stage count as tck, so they are sampled coherently with tck_rise.
- Latency: pad TCK rise reaches enable_o after SYNC_STAGES+1 clk_i cycles, i.e. 3 at the default.
- TCK timing: each TCK high and low phase must last at least SYNC_STAGES+1 clk_i cycles. Shorter phases are unsupported, and edges may be missed.
- FSM:
  - Standard 16 states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, plus the IR equivalents.
  - Transitions follow IEEE 1149.1 on sampled tms.
  - The state advances only in the cycle where tck_rise=1; otherwise it holds.
- Strobes:
  - capture/shift/update_dr_o are state levels, ANDed with the one-hot user selection.
  - A chain acts when enable_o & strobe are both high, i.e. on the rising TCK that leaves the state.
  - Update therefore occurs on the TCK rise that exits UPD_DR, not on the falling edge.
- IR:
  - On tck_rise in CAP_IR, the shift register loads {IR_WIDTH-2 zeros, 2'b01}.
  - In SH_IR it shifts right, with tdi entering the MSB.
  - On tck_rise in UPD_IR, ir_o takes the shift register value.
  - In TLR, ir_o = 1 (IDCODE).
- Instruction decode:
  - 1 selects IDCODE.
  - USER_BASE+k with k < NUM_DR selects user DR k.
  - Every other code, including all-ones, selects BYPASS.
- Internal DRs:
  - IDCODE: loads IDCODE_VAL in CAP_DR and shifts right in SH_DR.
  - BYPASS: 1 bit, loads 0 in CAP_DR and shifts tdi in SH_DR.
- TDO:
  - Updated only on tck_fall.
  - In SH_IR, jtag_tdo_o = IR shift LSB.
  - In SH_DR, jtag_tdo_o = LSB of IDCODE or BYPASS, or scan_out_i[k] for user DR k.
  - jtag_tdo_oe_o = 1 when the state is SH_IR or SH_DR at tck_fall; otherwise it drops to 0 at tck_fall.
- Reset:
  - rst_i=1 forces FSM=TLR and ir_o=1, and clears all shift registers to 0.
  - Synchronizers go to tck=0, tms=1, trst_n=1, so no false edge is seen after reset.
  - All outputs go to 0 (enable_o, strobes, jtag_tdo_o, jtag_tdo_oe_o); tdi_o=0.
- TRST: synchronized trst_n=0 forces FSM=TLR and ir_o=1 every cycle it is low, with priority over tck_rise. Shift registers are not cleared.
- Mid-operation: rst_i or TRST during SH_DR drops all strobes in the next cycle. External chains keep their contents, and no update pulse is issued.
- tck_rise and tck_fall are mutually exclusive by construction.

Test Plan:
- Reset and TLR entry:
  - Assert rst_i 2 cycles, then clock TCK with TMS=1 ×5.
  - Required: FSM stays TLR, ir_o=1, jtag_tdo_oe_o=0, all strobes 0, enable_o pulses once per TCK 3 clk_i after each pad rise.
- IDCODE readout:
  - From TLR, TMS sequence 0,1,0,0 to reach SH_DR, then shift 32 bits.
  - Required: TDO yields 32'h1000_2A5B LSB first, with jtag_tdo_oe_o high during the shift.
- IR scan to BYPASS:
  - Shift 5'h1F into the IR, capture the shifted-out value, then scan DR with pattern 1,0,1,1.
  - Required: captured IR value is 5'b00001; DR output is 0,1,0,1 (one-bit delay).
- User DR select:
  - Load IR=5'h09, then run a DR scan with 8 shift TCKs.
  - Required: capture_dr_o=2'b10 for 1 enable, shift_dr_o=2'b10 for 8 enables, update_dr_o=2'b10 for 1 enable.
  - Required: TDO follows scan_out_i[1] on each tck_fall; bit 0 of every strobe stays 0.
- TRST mid-shift:
  - Pull jtag_trst_ni low for 4 clk_i in SH_DR with IR=USER_BASE.
  - Required: FSM=TLR, ir_o=1 and strobes 0 within SYNC_STAGES+1 clk_i; no update_dr_o ever asserted.
- Synchronous reset mid-IR-shift:
  - Assert rst_i for 1 cycle in SH_IR.
  - Required: next cycle FSM=TLR, ir_o=1, jtag_tdo_oe_o=0; the subsequent TCK with TMS=1 produces no spurious enable_o before a real pad rise.
